// File: rtl/slon_rx.sv
// slon_rx: receive end of the slon source link. Oversamples the strobe
// clock, locks onto the incrementing data pattern, buffers words in a FIFO.
//   clk, rst          local clock, async active-high reset
//   in_clk, din       source strobe clock and data (async to clk)
//   m_data/m_valid/m_ready  FIFO head, valid/ready handshake
//   locked, clk_lost, err_cnt, overflow  link status
module slon_rx #(
  parameter int DIN_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 3,
  parameter int TIMEOUT       = 64,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_clk,
  input  logic [DIN_WIDTH-1:0]     din,
  output logic [DIN_WIDTH-1:0]     m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     locked,
  output logic                     clk_lost,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int LCW = $clog2(LOSS_COUNT + 1);

  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_PRE  = WDW'(TIMEOUT - 1);
  localparam logic [MCW-1:0] MC_LAST = MCW'(LOCK_COUNT - 1);
  localparam logic [LCW-1:0] LC_LAST = LCW'(LOSS_COUNT - 1);
  localparam logic [AW:0]    FULL    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  // sync_q[1:0] is the 2-flop synchronizer, sync_q[2] the edge register
  logic [2:0]           sync_q;
  logic                 sample_stb;
  logic                 in_edge;
  logic [DIN_WIDTH-1:0] rx_word_q;
  logic                 chk_q;
  logic [WDW-1:0]       wd_q;
  logic                 clk_lost_q;

  assign sample_stb = sync_q[2] & ~sync_q[1];
  assign in_edge    = sync_q[2] ^ sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      rx_word_q <= '0;
      chk_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], in_clk};
      chk_q  <= sample_stb;
      if (sample_stb) begin
        rx_word_q <= din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q       <= '0;
      clk_lost_q <= 1'b0;
    end else if (in_edge) begin
      wd_q       <= '0;
      clk_lost_q <= 1'b0;
    end else if (wd_q != WD_MAX) begin
      wd_q <= wd_q + 1'b1;
      if (wd_q == WD_PRE) begin
        clk_lost_q <= 1'b1;
      end
    end
  end

  state_t                   state_q;
  logic                     locked_q;
  logic                     seeded_q;
  logic [DIN_WIDTH-1:0]     expected_q;
  logic [MCW-1:0]           match_cnt_q;
  logic [LCW-1:0]           miss_cnt_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic                     match;

  // The first word after reset or loss has nothing to compare against;
  // it only seeds the expected value.
  assign match = seeded_q && (rx_word_q == expected_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      seeded_q    <= 1'b0;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else if (clk_lost_q) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      seeded_q    <= 1'b0;
      match_cnt_q <= '0;
    end else if (chk_q) begin
      unique case (state_q)
        HUNT: begin
          expected_q <= rx_word_q + 1'b1;
          seeded_q   <= 1'b1;
          if (!match) begin
            match_cnt_q <= '0;
          end else if (match_cnt_q == MC_LAST) begin
            state_q     <= LOCKED;
            locked_q    <= 1'b1;
            miss_cnt_q  <= '0;
            match_cnt_q <= '0;
          end else begin
            match_cnt_q <= match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          // free-running: a lone bad word costs exactly one error
          expected_q <= expected_q + 1'b1;
          if (match) begin
            miss_cnt_q <= '0;
          end else begin
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (miss_cnt_q == LC_LAST) begin
              state_q     <= HUNT;
              locked_q    <= 1'b0;
              seeded_q    <= 1'b0;
              match_cnt_q <= '0;
              miss_cnt_q  <= '0;
            end else begin
              miss_cnt_q <= miss_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  logic [DIN_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wp_q;
  logic [AW-1:0]        rp_q;
  logic [AW:0]          cnt_q;
  logic                 ovf_q;
  logic                 fifo_wr;
  logic                 fifo_rd;
  logic                 fifo_full;
  logic                 wr_ok;

  assign fifo_wr   = chk_q && (state_q == LOCKED) && !clk_lost_q;
  assign fifo_rd   = (cnt_q != '0) && m_ready;
  assign fifo_full = (cnt_q == FULL);
  // a read in the same cycle frees the slot for a write into a full FIFO
  assign wr_ok     = fifo_wr && (!fifo_full || fifo_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[wp_q] <= rx_word_q;
        wp_q        <= wp_q + 1'b1;
      end
      if (fifo_rd) begin
        rp_q <= rp_q + 1'b1;
      end
      case ({wr_ok, fifo_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (fifo_wr && fifo_full && !fifo_rd) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign m_data   = mem_q[rp_q];
  assign m_valid  = (cnt_q != '0);
  assign locked   = locked_q;
  assign clk_lost = clk_lost_q;
  assign err_cnt  = err_cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_slon_rx.sv
// tb_slon_rx: directed bench for slon_rx.
// Drives strobe/data words, records FIFO output, checks status flags.
module tb_slon_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_clk = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        locked;
  logic        clk_lost;
  logic [15:0] err_cnt;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fall = 0;
  logic [7:0] got[$];

  slon_rx dut (
    .clk      (clk),
    .rst      (rst),
    .in_clk   (in_clk),
    .din      (din),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .locked   (locked),
    .clk_lost (clk_lost),
    .err_cnt  (err_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && m_valid && m_ready) got.push_back(m_data);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rise(input logic [7:0] w);
    @(posedge clk); #1;
    in_clk = 1'b1;
    din    = w;
  endtask

  task automatic fall();
    @(posedge clk); #1;
    in_clk    = 1'b0;
    last_fall = cyc;
  endtask

  task automatic send_word(input logic [7:0] w);
    rise(w);
    tick(7);
    fall();
    tick(7);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    got.delete();
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (got.size() > i) ? 32'(got[i]) : 32'hDEAD;
  endfunction

  logic [7:0] glitch [4] = '{8'h10, 8'h11, 8'h55, 8'h13};
  int lat;

  initial begin
    tick(3);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_locked", locked, 0);
    check("rst_lost", clk_lost, 0);
    check("rst_err", err_cnt, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;

    // clean stream
    for (int i = 0; i < 4; i++) send_word(8'(i));
    check("clean_pre_lock", locked, 0);
    send_word(8'h04);
    check("clean_lock", locked, 1);
    check("clean_nowr", got.size(), 0);
    for (int i = 5; i < 9; i++) send_word(8'(i));
    check("clean_cnt", got.size(), 4);
    for (int i = 0; i < 4; i++) check("clean_data", q_at(i), i + 5);
    check("clean_err", err_cnt, 0);

    // wrap-around
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_word(8'(251 + i));
      if (i == 4) check("wrap_lock", locked, 1);
    end
    check("wrap_locked", locked, 1);
    check("wrap_err", err_cnt, 0);
    check("wrap_cnt", got.size(), 6);
    for (int i = 0; i < 6; i++) check("wrap_data", q_at(i), i);

    // single glitch
    do_reset();
    for (int i = 11; i < 16; i++) send_word(8'(i));
    got.delete();
    for (int i = 0; i < 4; i++) send_word(glitch[i]);
    check("gl_err", err_cnt, 1);
    check("gl_locked", locked, 1);
    check("gl_cnt", got.size(), 4);
    for (int i = 0; i < 4; i++) check("gl_data", q_at(i), 32'(glitch[i]));

    // loss of lock: expected runs on at 0x14
    got.delete();
    send_word(8'hA0);
    send_word(8'hA1);
    check("loss_hold", locked, 1);
    send_word(8'hA2);
    check("loss_unlock", locked, 0);
    check("loss_err", err_cnt, 4);
    for (int i = 0; i < 4; i++) send_word(8'(8'h30 + i));
    check("relock_pre", locked, 0);
    send_word(8'h34);
    check("relock", locked, 1);
    check("loss_cnt", got.size(), 3);
    check("loss_last", q_at(2), 32'hA2);
    send_word(8'h35);
    check("relock_cnt", got.size(), 4);
    check("relock_data", q_at(3), 32'h35);
    check("relock_err", err_cnt, 4);

    // clock stop
    lat = cyc - last_fall;
    while (!clk_lost && lat < 100) begin
      if (lat == 60) check("lost_early", clk_lost, 0);
      tick(1);
      lat = cyc - last_fall;
    end
    check("lost_seen", clk_lost, 1);
    check("lost_lat", (lat >= 64 && lat <= 68), 1);
    while (cyc - last_fall < 70) tick(1);
    check("lost_locked", locked, 0);
    check("lost_hold", clk_lost, 1);
    rise(8'h40);
    tick(5);
    check("lost_clear", clk_lost, 0);
    fall();
    tick(7);

    // backpressure
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 21; i++) send_word(8'(i));
    check("bp_ovf0", overflow, 0);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 8'h05);
    send_word(8'h15);
    check("bp_ovf1", overflow, 1);
    check("bp_stable", m_data, 8'h05);
    check("bp_nopop", got.size(), 0);
    m_ready = 1'b1;
    tick(20);
    check("bp_drain", got.size(), 16);
    check("bp_first", q_at(0), 32'h05);
    check("bp_last", q_at(15), 32'h14);
    m_ready = 1'b0;
    send_word(8'h16);
    check("bp_resume", m_data, 8'h16);
    check("bp_locked", locked, 1);

    // reset mid-word, no clock edge in between
    rise(8'h17);
    tick(3);
    rst = 1'b1;
    #1;
    check("mid_valid", m_valid, 0);
    check("mid_data", m_data, 0);
    check("mid_locked", locked, 0);
    check("mid_lost", clk_lost, 0);
    check("mid_err", err_cnt, 0);
    check("mid_ovf", overflow, 0);
    tick(2);
    rst = 1'b0;
    fall();
    tick(8);
    check("post_valid", m_valid, 0);
    check("post_locked", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
